sda_kernel_ctrl_block: RTL
==========================

Name: sda_kernel_ctrl_block

Overview:
Parametrised successor to the single-register kernel control path. It is an AXI4-Lite slave that implements the full SDAccel control map: ap_ctrl, GIE, IER, ISR and NUM_ARGS 32-bit argument registers. It drives the action go/done handshake from a run FSM with auto-restart, and generates ap_interrupt instead of tying it low. It sits between s_axi_control and the action core in every kernel wrapper.

Parameters:
ADDR_WIDTH, 6, s_axi_control address width in bits; must satisfy 2**ADDR_WIDTH >= 16+4*NUM_ARGS (elaboration error otherwise).
NUM_ARGS, 4, number of 32-bit argument registers at byte offsets 0x10, 0x14, and so on (range 0..(2**ADDR_WIDTH-16)/4).

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  reset, asynchronous assert, active-low
s_axi_control_AWADDR/AWVALID/AWREADY  in/in/out  ADDR_WIDTH/1/1  write address
s_axi_control_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data
s_axi_control_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response
s_axi_control_ARADDR/ARVALID/ARREADY  in/in/out  ADDR_WIDTH/1/1  read address
s_axi_control_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data
go_0r  out  1  action start request
go_0a  in  1  action start acknowledge
done_0r  in  1  action completion request
done_0a  out  1  completion acknowledge
args  out  32*NUM_ARGS  argument snapshot; arg i is bits [32i+31:32i]
ap_interrupt  out  1  level interrupt

Behaviour:
- Reset (ap_rst_n=0, async): all outputs 0, all registers 0, FSM in IDLE. AWREADY, WREADY and ARREADY rise on the first clock after release.
- Write channel: AW and W are accepted independently into one-deep holding registers. AWREADY = no AW held and BVALID low. WREADY is defined the same way for W.
- When AW and W are both held, the register update happens on that clock. BVALID rises the next cycle and is held until BREADY, then the holding registers clear. Only one write is outstanding.
- Read channel: ARREADY = !RVALID. RDATA/RRESP are registered on AR acceptance, RVALID rises the next cycle and is held until RREADY.
- Response codes: BRESP/RRESP = OKAY (00) for mapped offsets, SLVERR (10) otherwise. Unmapped reads return 0 and unmapped writes are dropped. Address bits [1:0] are ignored.
- 0x00 ap_ctrl:
  - bit0 ap_start: write 1 sets it, only when FSM is IDLE; cleared on the go_0a acceptance cycle.
  - bit1 ap_done: set when done is accepted; clear-on-read.
  - bit2 ap_idle = (state==IDLE).
  - bit3 ap_ready: set when go is accepted; clear-on-read.
  - bit7 auto_restart: read/write.
  - Other bits read 0. Writes take effect only if WSTRB[0].
- 0x04 GIE bit0 R/W. 0x08 IER bits[1:0] R/W (bit0 done, bit1 ready).
- 0x0C ISR bits[1:0]:
  - Set by an event when the matching IER bit is set.
  - Write-1-toggles.
  - Same-cycle update: isr <= (isr ^ (wdata[1:0] when written)) | events.
- Args: 0x10+4i are byte-strobed R/W shadow registers. The args output is copied from the shadows on the IDLE->GO (and DONE->GO) transition and is stable for the whole run. Host writes during a run do not affect the running action.
- Clear-on-read and set on the same cycle: set wins (the bit remains 1).
- ap_interrupt is registered: GIE & |ISR, asserted 1 cycle after the ISR update.
- Run FSM:
  - IDLE: ap_start=1 -> GO.
  - GO: go_0r=1; on go_0a=1 -> BUSY, go_0r drops the next cycle; ready event.
  - BUSY: done_0r=1 -> DONE, with done_0a=1 for exactly that one DONE cycle; done event.
  - DONE: auto_restart -> GO (ap_start re-set internally), else -> IDLE.
  - go_0a while not in GO and done_0r while not in BUSY are ignored.
- Reset mid-run: all state is discarded, the FSM returns to IDLE, and go_0r/done_0a drop immediately.

Decomposition:
- Package sda_kernel_ctrl_pkg:
  - Offset constants CTRL/GIE/IER/ISR/ARG_BASE.
  - ap_ctrl bit indices.
  - RESP_OKAY/RESP_SLVERR.
  - Enum run_state_t {IDLE, GO, BUSY, DONE}.
- One sub-module, sda_kernel_run_fsm:
  - Inputs: start, auto_restart, go_0a, done_0r.
  - Outputs: go_0r, done_0a, idle, ready_evt, done_evt, snap_en.
- The AXI slave and the register file stay in the top module.

Test Plan:
- Reset release: all outputs 0; read 0x00 -> RDATA=0x00000004, RRESP=00; ap_interrupt=0.
- Write args 0x10=0xDEADBEEF, 0x14=0x12345678, then 0x00=1; go_0a high 3 cycles later, done_0r 10 cycles after that -> args[63:0]=0x12345678_DEADBEEF from GO entry; done_0a pulses 1 cycle; read 0x00=0x0000000E; second read=0x00000004.
- GIE=1, IER=3: run once -> ISR=3 and ap_interrupt=1; write ISR=1 -> ISR=2, ap_interrupt=1; write ISR=2 -> ap_interrupt=0 the next cycle.
- auto_restart=1 with start: after done, go_0r reasserts within 1 cycle and ap_idle stays 0; write 0x10=0x55 mid-run -> args[31:0] changes only at the next GO entry.
- W presented 4 cycles before AW, BREADY held low 5 cycles -> single BVALID held 5 cycles; AWREADY=0 throughout; read 0x3C with NUM_ARGS=4 -> RRESP=10, RDATA=0.
- ap_rst_n pulsed low while in BUSY -> go_0r/done_0a=0 immediately; after release, read 0x00=0x00000004 and args=0.

Source files
------------

// File: rtl/sda_kernel_ctrl_pkg.sv
// rtl/sda_kernel_ctrl_pkg.sv - shared constants and types for the kernel control block
package sda_kernel_ctrl_pkg;

  localparam int unsigned OFF_CTRL     = 32'h00;
  localparam int unsigned OFF_GIE      = 32'h04;
  localparam int unsigned OFF_IER      = 32'h08;
  localparam int unsigned OFF_ISR      = 32'h0C;
  localparam int unsigned OFF_ARG_BASE = 32'h10;

  localparam int CTRL_START        = 0;
  localparam int CTRL_DONE         = 1;
  localparam int CTRL_IDLE         = 2;
  localparam int CTRL_READY        = 3;
  localparam int CTRL_AUTO_RESTART = 7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GO   = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } run_state_t;

endpackage

// File: rtl/sda_kernel_run_fsm.sv
// rtl/sda_kernel_run_fsm.sv - go/done handshake sequencer with auto-restart
module sda_kernel_run_fsm
  import sda_kernel_ctrl_pkg::*;
(
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic start,
  input  logic auto_restart,
  input  logic go_0a,
  input  logic done_0r,
  output logic go_0r,
  output logic done_0a,
  output logic idle,
  output logic ready_evt,
  output logic done_evt,
  output logic snap_en
);

  run_state_t state, state_next;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are Moore-style so an asynchronous reset drops go/done acks at once
  always_comb begin
    state_next = state;
    go_0r      = 1'b0;
    done_0a    = 1'b0;
    idle       = 1'b0;
    ready_evt  = 1'b0;
    done_evt   = 1'b0;
    snap_en    = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (start) begin
          state_next = GO;
          snap_en    = 1'b1;
        end
      end
      GO: begin
        go_0r = 1'b1;
        if (go_0a) begin
          state_next = BUSY;
          ready_evt  = 1'b1;
        end
      end
      BUSY: begin
        if (done_0r) begin
          state_next = DONE;
          done_evt   = 1'b1;
        end
      end
      DONE: begin
        done_0a = 1'b1;
        if (auto_restart) begin
          state_next = GO;
          snap_en    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/sda_kernel_ctrl_block.sv
// rtl/sda_kernel_ctrl_block.sv - AXI4-Lite control slave with run FSM, args and interrupt
module sda_kernel_ctrl_block
  import sda_kernel_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_ARGS   = 4
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [ADDR_WIDTH-1:0]    s_axi_control_AWADDR,
  input  logic                     s_axi_control_AWVALID,
  output logic                     s_axi_control_AWREADY,
  input  logic [31:0]              s_axi_control_WDATA,
  input  logic [3:0]               s_axi_control_WSTRB,
  input  logic                     s_axi_control_WVALID,
  output logic                     s_axi_control_WREADY,
  output logic [1:0]               s_axi_control_BRESP,
  output logic                     s_axi_control_BVALID,
  input  logic                     s_axi_control_BREADY,
  input  logic [ADDR_WIDTH-1:0]    s_axi_control_ARADDR,
  input  logic                     s_axi_control_ARVALID,
  output logic                     s_axi_control_ARREADY,
  output logic [31:0]              s_axi_control_RDATA,
  output logic [1:0]               s_axi_control_RRESP,
  output logic                     s_axi_control_RVALID,
  input  logic                     s_axi_control_RREADY,
  output logic                     go_0r,
  input  logic                     go_0a,
  input  logic                     done_0r,
  output logic                     done_0a,
  output logic [32*NUM_ARGS-1:0]   args,
  output logic                     ap_interrupt
);

  localparam int WW        = ADDR_WIDTH - 2;
  localparam int NUM_WORDS = int'(OFF_ARG_BASE / 4) + NUM_ARGS;
  localparam logic [WW-1:0] W_CTRL = WW'(OFF_CTRL / 4);
  localparam logic [WW-1:0] W_GIE  = WW'(OFF_GIE / 4);
  localparam logic [WW-1:0] W_IER  = WW'(OFF_IER / 4);
  localparam logic [WW-1:0] W_ISR  = WW'(OFF_ISR / 4);

  if ((2 ** ADDR_WIDTH) < 16 + 4 * NUM_ARGS) begin : g_addr_check
    $error("sda_kernel_ctrl_block: ADDR_WIDTH too small for NUM_ARGS");
  end

  function automatic logic is_mapped(input logic [WW-1:0] w);
    return 32'(w) < 32'(NUM_WORDS);
  endfunction

  // Byte-lane bits [1:0] never select a register
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_control_ARADDR[1:0], s_axi_control_AWADDR[1:0]};

  logic            ready_en;
  logic            aw_held, w_held, bvalid_q, rvalid_q;
  logic [WW-1:0]   aw_word;
  logic [31:0]     w_data, rdata_q, rd_value, ctrl_word;
  logic [3:0]      w_strb;
  logic [1:0]      bresp_q, rresp_q;
  logic [WW-1:0]   ar_word;
  logic            ar_fire, do_write;
  logic            ctrl_wr, gie_wr, ier_wr, isr_wr, rd_ctrl;

  logic            ap_start, ap_done, ap_ready, auto_restart, gie;
  logic [1:0]      ier, isr;
  logic [31:0]     arg_shadow [NUM_ARGS];
  logic            idle, ready_evt, done_evt, snap_en;

  assign s_axi_control_AWREADY = ready_en && !aw_held && !bvalid_q;
  assign s_axi_control_WREADY  = ready_en && !w_held && !bvalid_q;
  assign s_axi_control_ARREADY = ready_en && !rvalid_q;
  assign s_axi_control_BVALID  = bvalid_q;
  assign s_axi_control_BRESP   = bresp_q;
  assign s_axi_control_RVALID  = rvalid_q;
  assign s_axi_control_RRESP   = rresp_q;
  assign s_axi_control_RDATA   = rdata_q;

  assign ar_word  = s_axi_control_ARADDR[ADDR_WIDTH-1:2];
  assign ar_fire  = s_axi_control_ARVALID && s_axi_control_ARREADY;
  assign do_write = aw_held && w_held && !bvalid_q;
  assign ctrl_wr  = do_write && (aw_word == W_CTRL) && w_strb[0];
  assign gie_wr   = do_write && (aw_word == W_GIE) && w_strb[0];
  assign ier_wr   = do_write && (aw_word == W_IER) && w_strb[0];
  assign isr_wr   = do_write && (aw_word == W_ISR) && w_strb[0];
  assign rd_ctrl  = ar_fire && (ar_word == W_CTRL);

  sda_kernel_run_fsm u_run_fsm (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .start        (ap_start),
    .auto_restart (auto_restart),
    .go_0a        (go_0a),
    .done_0r      (done_0r),
    .go_0r        (go_0r),
    .done_0a      (done_0a),
    .idle         (idle),
    .ready_evt    (ready_evt),
    .done_evt     (done_evt),
    .snap_en      (snap_en)
  );

  always_comb begin
    ctrl_word                    = '0;
    ctrl_word[CTRL_START]        = ap_start;
    ctrl_word[CTRL_DONE]         = ap_done;
    ctrl_word[CTRL_IDLE]         = idle;
    ctrl_word[CTRL_READY]        = ap_ready;
    ctrl_word[CTRL_AUTO_RESTART] = auto_restart;
  end

  always_comb begin
    rd_value = '0;
    if (ar_word == W_CTRL)     rd_value = ctrl_word;
    else if (ar_word == W_GIE) rd_value = {31'd0, gie};
    else if (ar_word == W_IER) rd_value = {30'd0, ier};
    else if (ar_word == W_ISR) rd_value = {30'd0, isr};
    else begin
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (ar_word == WW'(int'(OFF_ARG_BASE / 4) + i)) rd_value = arg_shadow[i];
      end
    end
  end

  // Write path: AW and W captured independently, one write outstanding
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ready_en <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_word  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (s_axi_control_AWVALID && s_axi_control_AWREADY) begin
        aw_held <= 1'b1;
        aw_word <= s_axi_control_AWADDR[ADDR_WIDTH-1:2];
      end
      if (s_axi_control_WVALID && s_axi_control_WREADY) begin
        w_held <= 1'b1;
        w_data <= s_axi_control_WDATA;
        w_strb <= s_axi_control_WSTRB;
      end
      if (do_write) begin
        bvalid_q <= 1'b1;
        bresp_q  <= is_mapped(aw_word) ? RESP_OKAY : RESP_SLVERR;
      end
      if (bvalid_q && s_axi_control_BREADY) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_value;
      rresp_q  <= is_mapped(ar_word) ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_axi_control_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  // Event sets beat clear-on-read in the same cycle
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ap_start     <= 1'b0;
      ap_done      <= 1'b0;
      ap_ready     <= 1'b0;
      auto_restart <= 1'b0;
      gie          <= 1'b0;
      ier          <= '0;
      isr          <= '0;
      ap_interrupt <= 1'b0;
      args         <= '0;
      for (int i = 0; i < NUM_ARGS; i++) arg_shadow[i] <= '0;
    end else begin
      ap_start <= (ap_start && !ready_evt) || snap_en || (ctrl_wr && w_data[0] && idle);
      ap_done  <= (ap_done && !rd_ctrl) || done_evt;
      ap_ready <= (ap_ready && !rd_ctrl) || ready_evt;
      if (ctrl_wr) auto_restart <= w_data[CTRL_AUTO_RESTART];
      if (gie_wr)  gie <= w_data[0];
      if (ier_wr)  ier <= w_data[1:0];
      isr <= (isr ^ (isr_wr ? w_data[1:0] : 2'b00)) | {ready_evt & ier[1], done_evt & ier[0]};
      ap_interrupt <= gie & (|isr);
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (do_write && aw_word == WW'(int'(OFF_ARG_BASE / 4) + i)) begin
          for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) arg_shadow[i][8*b +: 8] <= w_data[8*b +: 8];
          end
        end
        if (snap_en) args[32*i +: 32] <= arg_shadow[i];
      end
    end
  end

endmodule
